// File: rtl/hex_text_parser.sv
// hex_text_parser: turns an ASCII hex text stream into binary bytes.
// Hex digit pairs form bytes (first digit is the MSB nibble), whitespace
// separates them, and anything else counts as an error. The byte and error
// counters saturate at all-ones.
// Optional feature macro: HEX_PARSE_COMMENT_EN. When it is defined, '#' starts
// a comment that runs to the next LF. When it is undefined, '#' is an ordinary
// error character.
module hex_text_parser #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [7:0]       in_char,
    output logic             out_valid,
    output logic [7:0]       out_byte,
    output logic [7:0]       last_byte,
    output logic             pending,
    output logic             err_pulse,
    output logic [CNT_W-1:0] byte_count,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0] ST_HI  = 2'd0;
    localparam logic [1:0] ST_LO  = 2'd1;
`ifdef HEX_PARSE_COMMENT_EN
    localparam logic [1:0] ST_CMT = 2'd2;
`endif

    logic [1:0]       state_q, state_d;
    logic [3:0]       hi_q, hi_d;
    logic             out_valid_q;
    logic             err_pulse_q;
    logic [7:0]       out_byte_q;
    logic [7:0]       last_byte_q;
    logic [CNT_W-1:0] byte_count_q;
    logic [ERR_W-1:0] err_count_q;

    logic             is_hex;
    logic             is_sep;
    logic [3:0]       nib;
    logic             emit;
    logic             err;
`ifdef HEX_PARSE_COMMENT_EN
    logic             is_hash;
    logic             is_lf;
`endif

    // Classify the incoming character and convert hex digits to a nibble.
    // Digit offsets: '0'..'9' map to low bits directly, 'A'/'a' (0x41/0x61)
    // have low bits 1, so adding 9 yields 10..15.
    always_comb begin
        is_hex = 1'b1;
        nib    = 4'd0;
        if (in_char >= 8'h30 && in_char <= 8'h39) begin
            nib = in_char[3:0];
        end else if ((in_char >= 8'h41 && in_char <= 8'h46) ||
                     (in_char >= 8'h61 && in_char <= 8'h66)) begin
            nib = in_char[3:0] + 4'd9;
        end else begin
            is_hex = 1'b0;
        end
        is_sep = (in_char == 8'h20) || (in_char == 8'h09) ||
                 (in_char == 8'h0D) || (in_char == 8'h0A);
`ifdef HEX_PARSE_COMMENT_EN
        is_hash = (in_char == 8'h23);
        is_lf   = (in_char == 8'h0A);
`endif
    end

    // Parser state machine: decides the next state and whether this
    // character emits a byte or raises an error (at most one of each).
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        emit    = 1'b0;
        err     = 1'b0;
        if (in_valid) begin
            case (state_q)
                ST_HI: begin
                    if (is_hex) begin
                        hi_d    = nib;
                        state_d = ST_LO;
`ifdef HEX_PARSE_COMMENT_EN
                    end else if (is_hash) begin
                        state_d = ST_CMT;
`endif
                    end else if (!is_sep) begin
                        err = 1'b1;
                    end
                end
                ST_LO: begin
                    if (is_hex) begin
                        emit    = 1'b1;
                        state_d = ST_HI;
`ifdef HEX_PARSE_COMMENT_EN
                    end else if (is_hash) begin
                        // Orphaned high nibble, then the comment runs as usual.
                        err     = 1'b1;
                        state_d = ST_CMT;
`endif
                    end else begin
                        // Orphaned high nibble: one error, nibble dropped.
                        err     = 1'b1;
                        state_d = ST_HI;
                    end
                end
`ifdef HEX_PARSE_COMMENT_EN
                ST_CMT: begin
                    if (is_lf) begin
                        state_d = ST_HI;
                    end
                end
`endif
                default: state_d = ST_HI;
            endcase
        end
    end

    // State, pulse, data and saturating counter registers. Reset beats clr,
    // and clr beats a character arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HI;
            hi_q         <= 4'd0;
            out_valid_q  <= 1'b0;
            err_pulse_q  <= 1'b0;
            out_byte_q   <= 8'd0;
            last_byte_q  <= 8'd0;
            byte_count_q <= '0;
            err_count_q  <= '0;
        end else if (clr) begin
            // last_byte and out_byte survive a parse restart.
            state_q      <= ST_HI;
            hi_q         <= 4'd0;
            out_valid_q  <= 1'b0;
            err_pulse_q  <= 1'b0;
            byte_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            out_valid_q <= emit;
            err_pulse_q <= err;
            if (emit) begin
                out_byte_q  <= {hi_q, nib};
                last_byte_q <= {hi_q, nib};
                if (!(&byte_count_q)) begin
                    byte_count_q <= byte_count_q + CNT_W'(1);
                end
            end
            if (err && !(&err_count_q)) begin
                err_count_q <= err_count_q + ERR_W'(1);
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign err_pulse  = err_pulse_q;
    assign out_byte   = out_byte_q;
    assign last_byte  = last_byte_q;
    assign pending    = (state_q == ST_LO);
    assign byte_count = byte_count_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_hex_text_parser.sv
// Testbench for hex_text_parser: directed scenarios plus a randomized stream
// checked against a character-level reference model. A narrow byte counter
// keeps the saturation scenario short.
module tb_hex_text_parser;

    localparam int CW = 10;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_char = 8'h00;
    logic          out_valid;
    logic [7:0]    out_byte;
    logic [7:0]    last_byte;
    logic          pending;
    logic          err_pulse;
    logic [CW-1:0] byte_count;
    logic [EW-1:0] err_count;

    int checks = 0;
    int errors = 0;

    hex_text_parser #(.CNT_W(CW), .ERR_W(EW)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_char    (in_char),
        .out_valid  (out_valid),
        .out_byte   (out_byte),
        .last_byte  (last_byte),
        .pending    (pending),
        .err_pulse  (err_pulse),
        .byte_count (byte_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // Monitor: collects emitted bytes and error pulses, sampled mid-cycle.
    logic [7:0] got_bytes[$];
    int         got_errs = 0;
    always @(negedge clk) begin
        if (out_valid) got_bytes.push_back(out_byte);
        if (err_pulse) got_errs++;
    end

    // Reference model: applies the character rules directly to a string
    // of characters, counting bytes and errors without limits.
    bit         m_have_hi;
    int         m_hi;
    bit         m_in_cmt;
    logic [7:0] exp_bytes[$];
    int         exp_errs;

    function automatic int hexval(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - int'("0");
        if (c >= "A" && c <= "F") return int'(c) - int'("A") + 10;
        if (c >= "a" && c <= "f") return int'(c) - int'("a") + 10;
        return -1;
    endfunction

    function automatic bit is_space(input logic [7:0] c);
        return (c == 8'h20) || (c == 8'h09) || (c == 8'h0D) || (c == 8'h0A);
    endfunction

    task automatic model_reset();
        m_have_hi = 1'b0;
        m_hi      = 0;
        m_in_cmt  = 1'b0;
        exp_bytes.delete();
        exp_errs  = 0;
    endtask

    task automatic model_char(input logic [7:0] c);
        int v;
        v = hexval(c);
        if (m_in_cmt) begin
            if (c == 8'h0A) m_in_cmt = 1'b0;
            return;
        end
`ifdef HEX_PARSE_COMMENT_EN
        if (c == 8'h23) begin
            if (m_have_hi) exp_errs++;
            m_have_hi = 1'b0;
            m_in_cmt  = 1'b1;
            return;
        end
`endif
        if (v >= 0) begin
            if (m_have_hi) begin
                exp_bytes.push_back(8'(m_hi * 16 + v));
                m_have_hi = 1'b0;
            end else begin
                m_hi      = v;
                m_have_hi = 1'b1;
            end
        end else if (is_space(c)) begin
            if (m_have_hi) exp_errs++;
            m_have_hi = 1'b0;
        end else begin
            exp_errs++;
            m_have_hi = 1'b0;
        end
    endtask

    // Stimulus primitives.
    task automatic drive(input logic [7:0] c);
        in_valid = 1'b1;
        in_char  = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) drive(s[i]);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_char = "5";
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse got %b exp 0", err_pulse); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b exp 0", pending); end
        checks++; if (out_byte !== 8'h00) begin errors++; $display("FAIL reset_out_byte got %h exp 00", out_byte); end
        checks++; if (last_byte !== 8'h00) begin errors++; $display("FAIL reset_last_byte got %h exp 00", last_byte); end
        checks++; if (byte_count !== '0) begin errors++; $display("FAIL reset_byte_count got %0d exp 0", byte_count); end
        checks++; if (err_count !== '0) begin errors++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
        rst = 1'b0;
        in_valid = 1'b0;
        idle(2);
        checks++; if (got_bytes.size() != 0 || got_errs != 0) begin errors++; $display("FAIL reset_drop got bytes=%0d errs=%0d exp 0/0", got_bytes.size(), got_errs); end
    endtask

    task automatic test_basic();
        int b0;
        b0 = got_bytes.size();
        drive("3");
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL basic_pending_rise got %b exp 1", pending); end
        drive("A");
        checks++; if (out_valid !== 1'b1 || out_byte !== 8'h3A) begin errors++; $display("FAIL basic_latency got v=%b b=%h exp 1/3a", out_valid, out_byte); end
        send_str(" f0\n");
        idle(2);
        checks++; if (got_bytes.size() - b0 != 2) begin errors++; $display("FAIL basic_nbytes got %0d exp 2", got_bytes.size() - b0); end
        else begin
            checks++; if (got_bytes[b0] !== 8'h3A || got_bytes[b0+1] !== 8'hF0) begin errors++; $display("FAIL basic_bytes got %h %h exp 3a f0", got_bytes[b0], got_bytes[b0+1]); end
        end
        checks++; if (byte_count !== CW'(2)) begin errors++; $display("FAIL basic_byte_count got %0d exp 2", byte_count); end
        checks++; if (err_count !== EW'(0)) begin errors++; $display("FAIL basic_err_count got %0d exp 0", err_count); end
        checks++; if (last_byte !== 8'hF0) begin errors++; $display("FAIL basic_last_byte got %h exp f0", last_byte); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL basic_pending got %b exp 0", pending); end
    endtask

    task automatic test_errors();
        int b0, e0;
        do_clr();
        b0 = got_bytes.size();
        e0 = got_errs;
        send_str("7 G12");
        idle(2);
        checks++; if (got_errs - e0 != 2) begin errors++; $display("FAIL err_pulses got %0d exp 2", got_errs - e0); end
        checks++; if (err_count !== EW'(2)) begin errors++; $display("FAIL err_count got %0d exp 2", err_count); end
        checks++; if (byte_count !== CW'(1)) begin errors++; $display("FAIL err_byte_count got %0d exp 1", byte_count); end
        checks++; if (got_bytes.size() - b0 != 1 || last_byte !== 8'h12) begin errors++; $display("FAIL err_byte got n=%0d last=%h exp 1/12", got_bytes.size() - b0, last_byte); end
    endtask

    task automatic test_clr_drop();
        int b0, e0;
        do_clr();
        b0 = got_bytes.size();
        e0 = got_errs;
        drive("4");
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL clr_pending_before got %b exp 1", pending); end
        clr = 1'b1;
        in_valid = 1'b1;
        in_char = "5";
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL clr_pending got %b exp 0", pending); end
        checks++; if (out_valid !== 1'b0 || err_pulse !== 1'b0) begin errors++; $display("FAIL clr_pulses got %b%b exp 00", out_valid, err_pulse); end
        checks++; if (byte_count !== '0 || err_count !== '0) begin errors++; $display("FAIL clr_counts got %0d/%0d exp 0/0", byte_count, err_count); end
        checks++; if (last_byte !== 8'h12) begin errors++; $display("FAIL clr_last_byte_kept got %h exp 12", last_byte); end
        idle(2);
        checks++; if (got_bytes.size() != b0 || got_errs != e0) begin errors++; $display("FAIL clr_drop got bytes+%0d errs+%0d exp 0/0", got_bytes.size() - b0, got_errs - e0); end
        send_str("AB");
        idle(2);
        checks++; if (last_byte !== 8'hAB || byte_count !== CW'(1)) begin errors++; $display("FAIL clr_after got %h/%0d exp ab/1", last_byte, byte_count); end
    endtask

    task automatic test_comment();
        int b0;
        do_clr();
        b0 = got_bytes.size();
`ifdef HEX_PARSE_COMMENT_EN
        send_str("# zz 12\015\n34");
        idle(2);
        checks++; if (got_bytes.size() - b0 != 1 || last_byte !== 8'h34) begin errors++; $display("FAIL cmt_bytes got n=%0d last=%h exp 1/34", got_bytes.size() - b0, last_byte); end
        checks++; if (err_count !== EW'(0)) begin errors++; $display("FAIL cmt_err_count got %0d exp 0", err_count); end
        send_str("5#x\n67");
        idle(2);
        checks++; if (err_count !== EW'(1) || last_byte !== 8'h67) begin errors++; $display("FAIL cmt_hash_lo got %0d/%h exp 1/67", err_count, last_byte); end
`else
        send_str("#12");
        idle(2);
        checks++; if (err_count !== EW'(1)) begin errors++; $display("FAIL hash_err_count got %0d exp 1", err_count); end
        checks++; if (got_bytes.size() - b0 != 1 || last_byte !== 8'h12) begin errors++; $display("FAIL hash_byte got n=%0d last=%h exp 1/12", got_bytes.size() - b0, last_byte); end
`endif
    endtask

    task automatic test_random();
        int b0, e0, n;
        logic [7:0] c;
        string hexs;
        hexs = "0123456789abcdefABCDEF";
        do_clr();
        model_reset();
        b0 = got_bytes.size();
        e0 = got_errs;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: c = hexs[$urandom_range(0, 21)];
                6: c = 8'h20;
                7: c = ($urandom_range(0, 1) == 1) ? 8'h0A : 8'h09;
                8: c = 8'h23;
                default: c = 8'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) begin
                in_char = 8'($urandom);
                idle(1);
            end
            drive(c);
            model_char(c);
        end
        idle(2);
        n = got_bytes.size() - b0;
        checks++; if (n != exp_bytes.size()) begin errors++; $display("FAIL rnd_nbytes got %0d exp %0d", n, exp_bytes.size()); end
        for (int i = 0; i < n && i < exp_bytes.size(); i++) begin
            checks++; if (got_bytes[b0+i] !== exp_bytes[i]) begin errors++; $display("FAIL rnd_byte[%0d] got %h exp %h", i, got_bytes[b0+i], exp_bytes[i]); end
        end
        checks++; if (got_errs - e0 != exp_errs) begin errors++; $display("FAIL rnd_err_pulses got %0d exp %0d", got_errs - e0, exp_errs); end
        checks++; if (int'(err_count) != ((exp_errs > 255) ? 255 : exp_errs)) begin errors++; $display("FAIL rnd_err_count got %0d exp %0d", err_count, exp_errs); end
        checks++; if (int'(byte_count) != exp_bytes.size()) begin errors++; $display("FAIL rnd_byte_count got %0d exp %0d", byte_count, exp_bytes.size()); end
        checks++; if (pending !== m_have_hi) begin errors++; $display("FAIL rnd_pending got %b exp %b", pending, m_have_hi); end
        if (exp_bytes.size() > 0) begin
            checks++; if (last_byte !== exp_bytes[$]) begin errors++; $display("FAIL rnd_last_byte got %h exp %h", last_byte, exp_bytes[$]); end
        end
    endtask

    task automatic test_saturation();
        int b0, e0, nb;
        logic [7:0] b;
        nb = (1 << CW) + 6;
        do_clr();
        b0 = got_bytes.size();
        e0 = got_errs;
        b = 8'h00;
        for (int i = 0; i < nb; i++) begin
            b = 8'($urandom);
            drive((b[7:4] < 4'd10) ? 8'h30 + 8'(b[7:4]) : 8'h57 + 8'(b[7:4]));
            drive((b[3:0] < 4'd10) ? 8'h30 + 8'(b[3:0]) : 8'h37 + 8'(b[3:0]));
        end
        checks++; if (out_valid !== 1'b1 || out_byte !== b) begin errors++; $display("FAIL sat_final_pulse got %b/%h exp 1/%h", out_valid, out_byte, b); end
        idle(2);
        checks++; if (byte_count !== {CW{1'b1}}) begin errors++; $display("FAIL sat_byte_count got %0d exp %0d", byte_count, (1 << CW) - 1); end
        checks++; if (got_bytes.size() - b0 != nb) begin errors++; $display("FAIL sat_nbytes got %0d exp %0d", got_bytes.size() - b0, nb); end
        for (int i = 0; i < 300; i++) drive("G");
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL sat_final_err_pulse got %b exp 1", err_pulse); end
        idle(2);
        checks++; if (err_count !== {EW{1'b1}}) begin errors++; $display("FAIL sat_err_count got %0d exp 255", err_count); end
        checks++; if (got_errs - e0 != 300) begin errors++; $display("FAIL sat_err_pulses got %0d exp 300", got_errs - e0); end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_clr_drop();
        test_comment();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
